// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Drives the instruction memory read
//            address, tracks the fixed read latency and buffers returned
//            (pc, instr) pairs in a credit-guarded FIFO towards decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned LATENCY  = 2,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_raddr,
    input  logic [15:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    output logic [15:0] out_pc,
    output logic [15:0] out_instr,
    input  logic        out_ready
);

    localparam int unsigned c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned c_INF_W = $clog2(LATENCY + 1);
    localparam int unsigned c_OCC_W = c_CNT_W + 1;

    logic [15:0]        r_pc;
    logic [LATENCY-1:0] r_pipe_vld;
    logic [15:0]        r_pipe_pc [LATENCY];
    logic [c_INF_W-1:0] r_inflight_cnt;

    logic [15:0]        r_fifo_pc    [DEPTH];
    logic [15:0]        r_fifo_instr [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_fifo_cnt;

    logic [c_OCC_W-1:0] w_occupancy;
    logic               w_issue;
    logic               w_ret;
    logic               w_push;
    logic               w_pop;

    // Credits count both buffered and in-flight words, so the memory (which
    // cannot be stalled) always finds a free FIFO slot when its data returns.
    always_comb begin
        w_occupancy = c_OCC_W'(r_fifo_cnt) + c_OCC_W'(r_inflight_cnt);
        w_issue     = !redirect_valid && (w_occupancy < c_OCC_W'(DEPTH));
        w_ret       = r_pipe_vld[LATENCY-1];
        w_push      = w_ret && !redirect_valid;
        w_pop       = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_issue) begin
            r_pc <= r_pc + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || redirect_valid) begin
            r_pipe_vld <= '0;
        end else begin
            for (int i = int'(LATENCY) - 1; i > 0; i--) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
            r_pipe_vld[0] <= w_issue;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = int'(LATENCY) - 1; i > 0; i--) begin
            r_pipe_pc[i] <= r_pipe_pc[i-1];
        end
        r_pipe_pc[0] <= r_pc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || redirect_valid) begin
            r_inflight_cnt <= '0;
        end else begin
            case ({w_issue, w_ret})
                2'b10:   r_inflight_cnt <= r_inflight_cnt + c_INF_W'(1);
                2'b01:   r_inflight_cnt <= r_inflight_cnt - c_INF_W'(1);
                default: r_inflight_cnt <= r_inflight_cnt;
            endcase
        end
    end

    // A pop in the redirect cycle is honoured by the consumer; the flush then
    // discards whatever remains, so clearing the pointers covers both cases.
    always_ff @(posedge clk) begin
        if (!rst_n || redirect_valid) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_CNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_CNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            if (w_push) begin
                assert (r_fifo_cnt != c_CNT_W'(DEPTH));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wptr]    <= r_pipe_pc[LATENCY-1];
            r_fifo_instr[r_wptr] <= mem_rdata;
        end
    end

    assign mem_raddr = r_pc;
    assign out_valid = (r_fifo_cnt != '0);
    assign out_pc    = r_fifo_pc[r_rptr];
    assign out_instr = r_fifo_instr[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed bench for fetch_unit with a queue-based scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [15:0] c_RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_raddr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic        out_ready;

    logic [15:0] mem_d1 = 16'h0000;
    logic [31:0] exp_q [$];
    logic [31:0] sb_e;
    int          n_tests = 0;
    int          n_fail  = 0;

    fetch_unit #(
        .RESET_PC (c_RESET_PC),
        .LATENCY  (2),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_raddr      (mem_raddr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memword(input logic [15:0] a);
        return a + 16'h1000;
    endfunction

    // Two-cycle read memory: mem[i] = 0x1000 + i
    always @(posedge clk) begin
        mem_d1    <= memword(mem_raddr);
        mem_rdata <= mem_d1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] pc);
        exp_q.push_back({pc, memword(pc)});
    endtask

    task automatic push_range(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            push_exp(first + 16'(i));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no output", out_pc, out_instr);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_pc", 32'(out_pc), 32'(sb_e[31:16]));
                check("sb_instr", 32'(out_instr), 32'(sb_e[15:0]));
            end
        end
    end

    task automatic drain();
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && cyc < 200) begin
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending outputs, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Leaves the bench at the start of cycle 0 with rst_n just released.
    task automatic do_reset(input bit with_redir);
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = with_redir;
        redirect_pc    = 16'h0555;
        tick();
        tick();
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_pc", 32'(mem_raddr), 32'(c_RESET_PC));
        tick();
        redirect_valid = 1'b0;
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;

        // 1: streaming from reset, first output LATENCY+1 cycles after issue
        do_reset(1'b0);
        out_ready = 1'b1;
        push_range(16'h0000, 12);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_first_valid", 32'(out_valid), 32'(k == 3));
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t1_no_gap", 32'(out_valid), 32'd1);
        end
        tick();
        drain();

        // 2: back-pressure from reset (reset asserted together with redirect)
        do_reset(1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t2_raddr", 32'(mem_raddr), (k < 4) ? 32'(k) : 32'd4);
        end
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_head_pc", 32'(out_pc), 32'h0000);
        check("t2_head_instr", 32'(out_instr), 32'h1000);
        tick();
        push_range(16'h0000, 6);
        drain();

        // 3: redirect with two in flight and two buffered
        do_reset(1'b0);
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        @(negedge clk);
        check("t3_pre_valid", 32'(out_valid), 32'd1);
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_redir_valid", 32'(out_valid), 32'(k == 3));
        end
        check("t3_pc", 32'(out_pc), 32'h0100);
        check("t3_instr", 32'(out_instr), 32'h1100);
        tick();
        push_range(16'h0100, 4);
        drain();

        // 4: PC wrap-around
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        tick();
        redirect_valid = 1'b0;
        push_range(16'hFFFE, 4);
        drain();

        // 5: reset mid-stream; in-flight pre-reset reads must be dropped
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0020;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        push_range(16'h0020, 3);
        repeat (6) tick();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        tick();
        check("t5_consumed", 32'(exp_q.size()), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        push_range(16'h0000, 4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_restart_valid", 32'(out_valid), 32'(k == 3));
        end
        tick();
        drain();

        // 6: head consumed in the redirect cycle, rest flushed
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0007;
        tick();
        redirect_valid = 1'b0;
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0200;
        out_ready      = 1'b1;
        push_exp(16'h0007);
        @(negedge clk);
        check("t6_head_valid", 32'(out_valid), 32'd1);
        check("t6_head_pc", 32'(out_pc), 32'h0007);
        tick();
        redirect_valid = 1'b0;
        push_range(16'h0200, 4);
        @(negedge clk);
        check("t6_flushed", 32'(out_valid), 32'd0);
        tick();
        drain();

        // 7: back-to-back redirects, the last one wins
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0300;
        tick();
        redirect_pc    = 16'h0400;
        tick();
        redirect_valid = 1'b0;
        push_range(16'h0400, 3);
        drain();

        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the instruction memory. It drives the memory's read port 0 address, tracks the memory's fixed 2-cycle read latency, and buffers returned instruction words in a small FIFO. The FIFO presents (pc, instr) pairs to decode through a valid/ready handshake. A credit scheme means the non-stallable memory can never overflow the FIFO, and a redirect input (branch/jump) flushes all queued and in-flight work.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset.
LATENCY, 2, cycles from address driven to data valid on mem_rdata; must equal the memory's read latency.
DEPTH, 4, output FIFO entries. Must satisfy DEPTH >= LATENCY+2 for one instruction per cycle; power of two.

Ports:
clk  input  1  clock; all state updates on posedge.
rst_n  input  1  synchronous active-low reset.
mem_raddr  output  16  read address to memory port 0; equals the current PC register.
mem_rdata  input  16  read data from memory port 0; data for the address driven in cycle n is valid in cycle n+LATENCY.
redirect_valid  input  1  load a new PC and flush the pipeline this cycle.
redirect_pc  input  16  target PC, sampled when redirect_valid=1.
out_valid  output  1  FIFO head valid.
out_pc  output  16  PC of the head instruction.
out_instr  output  16  head instruction word.
out_ready  input  1  consumer accepts the head when out_valid && out_ready.

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc <= RESET_PC; FIFO emptied; in-flight valid pipe cleared; count registers <= 0.
  - out_valid=0 from the following cycle; out_pc/out_instr are don't-care while out_valid=0.
  - Responses returning after reset from pre-reset requests are discarded.
- Issue: issue = !redirect_valid && (fifo_count + inflight_count < DEPTH), using current-cycle registered counts. There is no credit bypass from a same-cycle pop.
  - On issue: the pc value is recorded in a LATENCY-deep shift pipe with a valid bit, and pc <= pc+1 (16-bit, 0xFFFF wraps to 0x0000, no masking to memory size).
  - No issue: pc holds. mem_raddr still shows pc, but the pipe slot is marked invalid.
- Return: when the pipe's oldest slot is valid, {slot_pc, mem_rdata} is pushed into the FIFO at that cycle's posedge. The FIFO can never be full at a push; the credit rule guarantees this. Treat a push to a full FIFO as an assertion failure in simulation.
- Output: out_valid = (fifo_count != 0); head is registered FIFO storage. There is no bypass, so an instruction pushed in cycle m is visible at the earliest in cycle m+1.
  - Best-case fetch-to-output latency is LATENCY+1 cycles: address in cycle n, out_valid in cycle n+3 at default.
- Simultaneous push and pop: both occur; fifo_count is unchanged.
- Redirect (redirect_valid=1 in cycle r):
  - At the posedge ending r: pc <= redirect_pc, all pipe valid bits cleared, FIFO emptied.
  - A head handshake (out_valid && out_ready) in cycle r still counts as consumed; the flush discards everything else.
  - No issue occurs in cycle r. redirect_pc is driven in cycle r+1, and its instruction appears on out_valid in cycle r+4.
- Redirect and reset together: reset wins (pc <= RESET_PC).
- Consecutive redirects: the last one wins; each flushes.
- The block never writes memory; the memory write port and read port 1 belong to other stages.

Test Plan:
1. Preload mem[i]=16'h1000+i; release reset; hold out_ready=1.
   -> out_valid first high 3 cycles after the first issue cycle with pc=0000/instr=1000, then pc 1,2,3… every cycle with no gaps.
2. Hold out_ready=0 from reset.
   -> mem_raddr steps 0,1,2,3 then holds at 4; exactly 4 entries buffered; out_pc=0000.
   Then set out_ready=1 -> pcs 0,1,2,3,4,5 in order with no duplicates.
3. With 2 requests in flight and 2 buffered, pulse redirect_valid with redirect_pc=0100 for one cycle.
   -> out_valid=0 the next cycle; no stale pcs ever appear; first output is pc=0100, instr=mem[0100], 4 cycles after the redirect cycle.
4. Redirect to FFFE with out_ready=1.
   -> output pcs FFFE, FFFF, 0000, 0001 with matching memory words.
5. Drop rst_n for one cycle mid-stream.
   -> out_valid=0 the next cycle; fetch restarts at RESET_PC; no pre-reset data is delivered.
6. Assert redirect_valid and out_ready together while out_valid=1 with pc=0007.
   -> pc 0007 counts as consumed, FIFO flushed; the next delivered pc is the redirect target.
